// File: rtl/mux_select_ctrl_if.sv
// Pin-side bundle for mux_select_ctrl: raw buttons/switch in, select and status out.
interface mux_select_ctrl_if #(
    parameter int NUM_BUTTONS = 5,
    parameter int SEL_W       = 3
);
    logic [NUM_BUTTONS-1:0] buttons;
    logic                   switch;
    logic [SEL_W-1:0]       out;
    logic                   held;
    logic                   sel_valid;
    logic                   sel_changed;

    modport master (
        output buttons, switch,
        input  out, held, sel_valid, sel_changed
    );

    modport slave (
        input  buttons, switch,
        output out, held, sel_valid, sel_changed
    );
endinterface

// File: rtl/mux_select_ctrl.sv
// Debounced push-button to mux select encoder with a hold switch.
// Optional MUX_SEL_STICKY_EN: in LIVE, keep the last nonzero select when no button is down.
module mux_select_ctrl #(
    parameter int NUM_BUTTONS     = 5,
    parameter int SEL_W           = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input logic              clock,
    input logic              reset,
    mux_select_ctrl_if.slave bus
);

    localparam int NI = NUM_BUTTONS + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [0:0] LIVE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    if (NUM_BUTTONS < 1 || NUM_BUTTONS > 15) begin : g_bad_nb
        $error("mux_select_ctrl: NUM_BUTTONS out of range");
    end
    if ((2 ** SEL_W) < NUM_BUTTONS + 1) begin : g_bad_sel
        $error("mux_select_ctrl: SEL_W too small");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("mux_select_ctrl: DEBOUNCE_CYCLES must be >= 1");
    end
    if (DEBOUNCE_CYCLES >= (2 ** CNT_W)) begin : g_bad_cnt
        $error("mux_select_ctrl: CNT_W too small");
    end

    // Switch rides along as the top input so it shares the sync/debounce path.
    logic [NI-1:0]    raw;
    logic [NI-1:0]    sync1_q, sync1_d;
    logic [NI-1:0]    sync2_q, sync2_d;
    logic [NI-1:0]    db_q, db_d;
    logic [CNT_W-1:0] cnt_q [NI];
    logic [CNT_W-1:0] cnt_d [NI];

    logic [0:0]       state_q, state_d;
    logic             sw_prev_q, sw_prev_d;
    logic [SEL_W-1:0] held_sel_q, held_sel_d;
    logic [SEL_W-1:0] out_q, out_d;
    logic             held_q, held_d;
    logic             valid_q, valid_d;
    logic             chg_q, chg_d;

    logic             sw_db;
    logic             sw_rise;
    logic             sw_fall;
    logic [SEL_W-1:0] live_sel;
    logic [SEL_W-1:0] live_out;

    assign raw     = {bus.switch, bus.buttons};
    assign sync1_d = raw;
    assign sync2_d = sync1_q;

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NI; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        live_sel = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (db_q[i]) begin
                live_sel = SEL_W'(i + 1);
            end
        end
    end

`ifdef MUX_SEL_STICKY_EN
    assign live_out = (live_sel != '0) ? live_sel : out_q;
`else
    assign live_out = live_sel;
`endif

    assign sw_db     = db_q[NUM_BUTTONS];
    assign sw_prev_d = sw_db;
    assign sw_rise   = sw_db & ~sw_prev_q;
    assign sw_fall   = ~sw_db & sw_prev_q;

    always_comb begin
        state_d    = state_q;
        held_sel_d = held_sel_q;
        out_d      = out_q;
        unique case (state_q)
            LIVE: begin
                out_d = live_out;
                if (sw_rise) begin
                    state_d    = HOLD;
                    held_sel_d = live_out;
                end
            end
            HOLD: begin
                out_d = held_sel_q;
                if (sw_fall) begin
                    state_d = LIVE;
                    out_d   = live_out;
                end
            end
            default: state_d = LIVE;
        endcase
    end

    assign held_d  = (state_d == HOLD);
    assign valid_d = (out_d != '0);
    assign chg_d   = (out_d != out_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            for (int i = 0; i < NI; i++) begin
                cnt_q[i] <= '0;
            end
            state_q    <= LIVE;
            sw_prev_q  <= 1'b0;
            held_sel_q <= '0;
            out_q      <= '0;
            held_q     <= 1'b0;
            valid_q    <= 1'b0;
            chg_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            for (int i = 0; i < NI; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q    <= state_d;
            sw_prev_q  <= sw_prev_d;
            held_sel_q <= held_sel_d;
            out_q      <= out_d;
            held_q     <= held_d;
            valid_q    <= valid_d;
            chg_q      <= chg_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.held        = held_q;
    assign bus.sel_valid   = valid_q;
    assign bus.sel_changed = chg_q;

endmodule

// File: tb/tb_mux_select_ctrl.sv
// Scoreboard bench for mux_select_ctrl, default build (sticky mode off).
module tb_mux_select_ctrl;

    localparam int NB  = 5;
    localparam int SW  = 3;
    localparam int LAT = 7;

    typedef struct {
        int         cyc;
        string      tag;
        logic [2:0] out;
        logic       held;
        logic       chg;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   n_chk;
    int   n_pass;
    exp_t sb[$];

    mux_select_ctrl_if #(.NUM_BUTTONS(NB), .SEL_W(SW)) bus ();

    mux_select_ctrl #(
        .NUM_BUTTONS    (NB),
        .SEL_W          (SW),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic expect_at(input int c, input string tag,
                             input logic [2:0] o, input logic h,
                             input logic ch);
        exp_t e;
        e.cyc  = c;
        e.tag  = tag;
        e.out  = o;
        e.held = h;
        e.chg  = ch;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    chk($sformatf("%s@%0d.out", sb[i].tag, cyc),
                        int'(bus.out), int'(sb[i].out));
                    chk($sformatf("%s@%0d.held", sb[i].tag, cyc),
                        int'(bus.held), int'(sb[i].held));
                    chk($sformatf("%s@%0d.valid", sb[i].tag, cyc),
                        int'(bus.sel_valid), int'(sb[i].out != 3'd0));
                    chk($sformatf("%s@%0d.chg", sb[i].tag, cyc),
                        int'(bus.sel_changed), int'(sb[i].chg));
                    sb.delete(i);
                end
            end
        end
    end

    int t;

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        reset       = 1'b1;
        bus.buttons = '0;
        bus.switch  = 1'b0;
        tick(2);
        chk("rst.out", int'(bus.out), 0);
        chk("rst.held", int'(bus.held), 0);
        chk("rst.valid", int'(bus.sel_valid), 0);
        chk("rst.chg", int'(bus.sel_changed), 0);
        reset = 1'b0;

        // Single press and release
        tick(10);
        t = cyc;
        bus.buttons = 5'b00100;
        expect_at(t + LAT - 1, "s1_pre", 3'd0, 1'b0, 1'b0);
        expect_at(t + LAT, "s1_on", 3'd3, 1'b0, 1'b1);
        expect_at(t + LAT + 1, "s1_on1", 3'd3, 1'b0, 1'b0);
        tick(12);
        t = cyc;
        bus.buttons = 5'b00000;
        expect_at(t + LAT - 1, "s1_rpre", 3'd3, 1'b0, 1'b0);
        expect_at(t + LAT, "s1_off", 3'd0, 1'b0, 1'b1);
        expect_at(t + LAT + 1, "s1_off1", 3'd0, 1'b0, 1'b0);
        tick(12);

        // 3-cycle glitch must be filtered
        t = cyc;
        bus.buttons = 5'b10000;
        for (int k = 2; k <= 12; k++) expect_at(t + k, "s2_glitch", 3'd0, 1'b0, 1'b0);
        tick(3);
        bus.buttons = 5'b00000;
        tick(12);

        // Priority: highest pressed index wins
        t = cyc;
        bus.buttons = 5'b00011;
        expect_at(t + LAT, "s3_two", 3'd2, 1'b0, 1'b1);
        expect_at(t + LAT + 1, "s3_two1", 3'd2, 1'b0, 1'b0);
        tick(10);
        t = cyc;
        bus.buttons = 5'b10011;
        expect_at(t + LAT - 1, "s3_pre", 3'd2, 1'b0, 1'b0);
        expect_at(t + LAT, "s3_five", 3'd5, 1'b0, 1'b1);
        tick(10);
        t = cyc;
        bus.buttons = 5'b00000;
        expect_at(t + LAT, "s3_clr", 3'd0, 1'b0, 1'b1);
        tick(10);

        // Hold freezes selection; release picks up live value
        t = cyc;
        bus.buttons = 5'b00100;
        expect_at(t + LAT, "s4_sel", 3'd3, 1'b0, 1'b1);
        tick(10);
        t = cyc;
        bus.switch = 1'b1;
        expect_at(t + LAT - 1, "s4_hpre", 3'd3, 1'b0, 1'b0);
        expect_at(t + LAT, "s4_hold", 3'd3, 1'b1, 1'b0);
        tick(10);
        t = cyc;
        bus.buttons = 5'b10100;
        expect_at(t + LAT, "s4_frz", 3'd3, 1'b1, 1'b0);
        expect_at(t + LAT + 3, "s4_frz3", 3'd3, 1'b1, 1'b0);
        tick(12);
        t = cyc;
        bus.switch = 1'b0;
        expect_at(t + LAT - 1, "s4_upre", 3'd3, 1'b1, 1'b0);
        expect_at(t + LAT, "s4_unh", 3'd5, 1'b0, 1'b1);
        expect_at(t + LAT + 1, "s4_unh1", 3'd5, 1'b0, 1'b0);
        tick(10);

        // Async reset while held
        t = cyc;
        bus.buttons = 5'b00100;
        expect_at(t + LAT, "s5_sel", 3'd3, 1'b0, 1'b1);
        tick(10);
        t = cyc;
        bus.switch = 1'b1;
        expect_at(t + LAT, "s5_hold", 3'd3, 1'b1, 1'b0);
        tick(10);
        #2;
        reset = 1'b1;
        #1;
        chk("s5_arst.out", int'(bus.out), 0);
        chk("s5_arst.held", int'(bus.held), 0);
        chk("s5_arst.valid", int'(bus.sel_valid), 0);
        chk("s5_arst.chg", int'(bus.sel_changed), 0);
        tick(2);
        reset = 1'b0;
        t = cyc;
        expect_at(t + LAT - 1, "s5_rpre", 3'd0, 1'b0, 1'b0);
        expect_at(t + LAT, "s5_rhold", 3'd3, 1'b1, 1'b1);
        expect_at(t + LAT + 1, "s5_rhold1", 3'd3, 1'b1, 1'b0);
        tick(10);
        t = cyc;
        bus.switch = 1'b0;
        bus.buttons = 5'b00000;
        expect_at(t + LAT, "s5_clr", 3'd0, 1'b0, 1'b1);
        tick(10);

        // Switch and button rise together
        t = cyc;
        bus.switch = 1'b1;
        bus.buttons = 5'b00010;
        expect_at(t + LAT - 1, "s6_pre", 3'd0, 1'b0, 1'b0);
        expect_at(t + LAT, "s6_cap", 3'd2, 1'b1, 1'b1);
        tick(10);
        t = cyc;
        bus.buttons = 5'b10010;
        expect_at(t + LAT, "s6_frz", 3'd2, 1'b1, 1'b0);
        tick(10);
        t = cyc;
        bus.switch = 1'b0;
        bus.buttons = 5'b00000;
        expect_at(t + LAT, "s6_rel", 3'd0, 1'b0, 1'b1);
        tick(10);

        for (int k = 0; k < 50 && sb.size() != 0; k++) tick(1);
        chk("sb_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
